fetch_unit: RTL and testbench

//  Instruction fetch stage: owns the PC, issues word reads on the instruction bus, and

---
 rtl/fetch_unit_pkg.sv | 23 ++
 rtl/fetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch stage: common scalar aliases, FSM state and
// the {pc, raw_instr} record delivered to decode.
package fetch_unit_pkg;

  typedef logic        u1;
  typedef logic [31:0] u32;
  typedef logic [63:0] u64;
  typedef u64          addr_t;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    addr_t pc;
    u32    raw_instr;
  } fetch_data_t;

  localparam addr_t PC_RESET = 64'h8000_0000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, keeps one read outstanding on the instruction bus and
// hands {pc, instr} to decode. Optional stall counter under FETCH_PERF_EN.
//
// state | meaning
// REQ   | presenting (or about to present) a read at req_addr
// WAIT  | address accepted, waiting for the data beat
// HOLD  | instruction held for decode, waiting for out_ready
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(PC_RESET)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ireq_valid,
  output logic [XLEN-1:0] ireq_addr,
  input  logic            iresp_addr_ok,
  input  logic            iresp_data_ok,
  input  logic [31:0]     iresp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [63:0]     perf_stall_cnt
`endif
);

  fetch_state_t    state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] req_addr;
  logic            drop, drop_n;
  logic            latch;
  logic            accept;
  logic            addr_pending;

  assign accept       = (state == REQ) && ireq_valid && iresp_addr_ok;
  // A presented address must stay on the bus until the bus takes it.
  assign addr_pending = (state == REQ) && ireq_valid && !iresp_addr_ok;

  always_comb begin
    state_n = state;
    drop_n  = drop;
    pc_n    = pc;
    latch   = 1'b0;
    if (redirect_valid) pc_n = {redirect_pc[XLEN-1:2], 2'b00};
    case (state)
      REQ: begin
        if (accept) begin
          if (iresp_data_ok) begin
            if (drop || redirect_valid) begin
              state_n = REQ;
              drop_n  = 1'b0;
            end else begin
              state_n = HOLD;
              latch   = 1'b1;
            end
          end else begin
            state_n = WAIT;
            drop_n  = drop | redirect_valid;
          end
        end else if (redirect_valid && ireq_valid) begin
          drop_n = 1'b1;
        end
      end
      WAIT: begin
        if (iresp_data_ok) begin
          if (drop || redirect_valid) begin
            state_n = REQ;
            drop_n  = 1'b0;
          end else begin
            state_n = HOLD;
            latch   = 1'b1;
          end
        end else begin
          drop_n = drop | redirect_valid;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          state_n = REQ;
        end else if (out_ready) begin
          state_n = REQ;
          pc_n    = pc + XLEN'(4);
        end
      end
      default: state_n = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= REQ;
      pc         <= RESET_PC;
      drop       <= 1'b0;
      ireq_valid <= 1'b0;
      req_addr   <= RESET_PC;
      out_pc     <= '0;
      out_instr  <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      drop       <= drop_n;
      ireq_valid <= (state_n == REQ);
      if (!addr_pending && state_n == REQ) req_addr <= pc_n;
      if (latch) begin
        out_pc    <= req_addr;
        out_instr <= iresp_data;
      end
    end
  end

  assign ireq_addr = req_addr;
  assign out_valid = (state == HOLD);

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
    end else if (!(state == HOLD && out_ready) && perf_stall_cnt != '1) begin
      perf_stall_cnt <= perf_stall_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: 0-wait fetches, bus and decode back-pressure,
// redirects in each state, mid-transaction reset and PC wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
`ifdef FETCH_PERF_EN
  logic [63:0] perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_addr_ok  (iresp_addr_ok),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [63:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One 0-wait fetch at address a with decode ready; leaves the DUT requesting a+4.
  task automatic fetch0(input string tag, input logic [63:0] a);
    chk({tag, " req_valid"}, ireq_valid, 1);
    chk({tag, " req_addr"}, ireq_addr, a);
    iresp_addr_ok = 1; iresp_data_ok = 1; iresp_data = mem(a); out_ready = 1;
    tick();
    iresp_addr_ok = 0; iresp_data_ok = 0; iresp_data = 32'h0;
    chk({tag, " out_valid"}, out_valid, 1);
    chk({tag, " out_pc"}, out_pc, a);
    chk({tag, " out_instr"}, out_instr, mem(a));
    chk({tag, " no_req_in_hold"}, ireq_valid, 0);
    tick();
    chk({tag, " out_valid_drop"}, out_valid, 0);
  endtask

  initial begin
    reset = 1; iresp_addr_ok = 0; iresp_data_ok = 0; iresp_data = 0;
    redirect_valid = 0; redirect_pc = 0; out_ready = 0;
    tick(); tick();
    chk("rst ireq_valid", ireq_valid, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_pc", out_pc, 0);
    chk("rst out_instr", out_instr, 0);
`ifdef FETCH_PERF_EN
    chk("rst perf", perf_stall_cnt, 0);
`endif
    reset = 0;
    tick();

    // 0-wait bus, decode always ready
    fetch0("t1a", 64'h8000_0000);
    fetch0("t1b", 64'h8000_0004);
    fetch0("t1c", 64'h8000_0008);

    // addr_ok held off for 3 cycles
    for (int i = 0; i < 3; i++) begin
      chk("t2 req_valid", ireq_valid, 1);
      chk("t2 req_addr", ireq_addr, 64'h8000_000C);
      tick();
    end
    chk("t2 req_valid4", ireq_valid, 1);
    chk("t2 req_addr4", ireq_addr, 64'h8000_000C);
    iresp_addr_ok = 1;
    tick();
    iresp_addr_ok = 0;
    chk("t2 wait no_req", ireq_valid, 0);
    chk("t2 wait out_valid", out_valid, 0);
    iresp_data_ok = 1; iresp_data = mem(64'h8000_000C); out_ready = 0;
    tick();
    iresp_data_ok = 0; iresp_data = 0;

    // decode stalls 5 cycles in HOLD
    for (int i = 0; i < 5; i++) begin
      chk("t3 out_valid", out_valid, 1);
      chk("t3 out_pc", out_pc, 64'h8000_000C);
      chk("t3 out_instr", out_instr, mem(64'h8000_000C));
      chk("t3 no_req", ireq_valid, 0);
      tick();
    end
    out_ready = 1;
    tick();
    chk("t3 next req_addr", ireq_addr, 64'h8000_0010);
    chk("t3 next req_valid", ireq_valid, 1);

    // redirect while in WAIT
    iresp_addr_ok = 1;
    tick();
    iresp_addr_ok = 0;
    redirect_valid = 1; redirect_pc = 64'h8000_0100;
    tick();
    redirect_valid = 0;
    chk("t4 still_wait", ireq_valid, 0);
    iresp_data_ok = 1; iresp_data = 32'hDEAD_BEEF;
    tick();
    iresp_data_ok = 0; iresp_data = 0;
    chk("t4 dropped", out_valid, 0);
    fetch0("t4", 64'h8000_0100);

    // redirect in HOLD with out_ready in the same cycle
    iresp_addr_ok = 1; iresp_data_ok = 1; iresp_data = mem(64'h8000_0104); out_ready = 0;
    tick();
    iresp_addr_ok = 0; iresp_data_ok = 0;
    chk("t5 hold out_pc", out_pc, 64'h8000_0104);
    redirect_valid = 1; redirect_pc = 64'h8000_0103; out_ready = 1;
    tick();
    redirect_valid = 0;
    chk("t5 out_valid_drop", out_valid, 0);
    fetch0("t5", 64'h8000_0100);

    // reset while WAIT, late data_ok afterwards
    iresp_addr_ok = 1;
    tick();
    iresp_addr_ok = 0;
    chk("t6 in_wait", ireq_valid, 0);
    reset = 1;
    tick();
    reset = 0;
    chk("t6 rst ireq_valid", ireq_valid, 0);
    chk("t6 rst out_valid", out_valid, 0);
`ifdef FETCH_PERF_EN
    chk("t6 rst perf", perf_stall_cnt, 0);
`endif
    iresp_data_ok = 1; iresp_data = 32'h1234_5678;
    tick();
    iresp_data_ok = 0; iresp_data = 0;
    chk("t6 late_data ignored", out_valid, 0);
`ifdef FETCH_PERF_EN
    chk("t6 perf count", perf_stall_cnt, 1);
`endif
    fetch0("t6", 64'h8000_0000);

    // redirect while an address is presented but not accepted, then PC wrap
    redirect_valid = 1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    redirect_valid = 0;
    chk("t7 addr_held", ireq_addr, 64'h8000_0004);
    chk("t7 valid_held", ireq_valid, 1);
    iresp_addr_ok = 1; iresp_data_ok = 1; iresp_data = 32'hBAD0_BAD0;
    tick();
    iresp_addr_ok = 0; iresp_data_ok = 0; iresp_data = 0;
    chk("t7 discarded", out_valid, 0);
    fetch0("t7", 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t7 wrap addr", ireq_addr, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
